// File: rtl/mantissa_mul_seq_pkg.sv
// Shared FP significand constants and the multiplier control-state encoding.
package mantissa_mul_seq_pkg;

  localparam int SIG_WIDTH  = 24;
  localparam int PROD_WIDTH = 2 * SIG_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mantissa_mul_seq_onebit_mul_step.sv
// One shift-and-add step: conditionally add A into hi, then shift {carry,hi,lo} right by one.
module onebit_mul_step #(
  parameter int WIDTH = mantissa_mul_seq_pkg::SIG_WIDTH
) (
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_sum;

  // The extra sum bit keeps the carry, which shifts into the top of hi.
  assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_a} : {(WIDTH + 1){1'b0}});
  assign o_hi  = w_sum[WIDTH:1];
  assign o_lo  = {w_sum[0], i_lo[WIDTH-1:1]};

endmodule

// File: rtl/mantissa_mul_seq.sv
// Sequential unsigned significand multiplier: one multiplier bit per clock, exact 2*WIDTH product.
module mantissa_mul_seq
  import mantissa_mul_seq_pkg::*;
#(
  parameter int WIDTH = SIG_WIDTH
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_start,
  input  logic [WIDTH-1:0]     in_multiplicand,
  input  logic [WIDTH-1:0]     in_multiplier,
  output logic                 out_busy,
  output logic                 out_done,
  output logic [2*WIDTH-1:0]   out_product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_t r_state;
  mul_state_t w_state_next;

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_hi_next;
  logic [WIDTH-1:0]   w_lo_next;
  logic               w_accept;
  logic               w_last;

  onebit_mul_step #(.WIDTH(WIDTH)) u_step (
    .i_hi (r_hi),
    .i_lo (r_lo),
    .i_a  (r_mcand),
    .o_hi (w_hi_next),
    .o_lo (w_lo_next)
  );

  assign w_last = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DONE accepts a new start just like IDLE, which gives back-to-back operation.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (in_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ST_RUN);
      r_done <= (w_state_next == ST_DONE);
      if (w_accept) begin
        r_mcand <= in_multiplicand;
        r_hi    <= '0;
        r_lo    <= in_multiplier;
        r_count <= '0;
      end else if (r_state == ST_RUN) begin
        r_hi    <= w_hi_next;
        r_lo    <= w_lo_next;
        r_count <= r_count + 1'b1;
        if (w_last) begin
          r_product <= {w_hi_next, w_lo_next};
        end
      end
    end
  end

  assign out_busy    = r_busy;
  assign out_done    = r_done;
  assign out_product = r_product;

endmodule

// File: tb/tb_mantissa_mul_seq.sv
// Randomised self-checking bench for mantissa_mul_seq against a plain-multiply reference.
module tb_mantissa_mul_seq;

  localparam int W = 24;

  logic             clk;
  logic             rst;
  logic             start;
  logic [W-1:0]     mcand;
  logic [W-1:0]     mplier;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int n_checks;
  int n_errors;

  mantissa_mul_seq #(.WIDTH(W)) dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_start        (start),
    .in_multiplicand (mcand),
    .in_multiplier   (mplier),
    .out_busy        (busy),
    .out_done        (done),
    .out_product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned la, lb;
    la = 64'(a);
    lb = 64'(b);
    return la * lb;
  endfunction

  // Runs one multiplication; with noise set, start pulses with garbage operands hit mid-RUN.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noise);
    int busy_cnt;
    int lat;
    logic [63:0] exp;
    exp = ref_mul(a, b);
    @(negedge clk);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    mcand    = W'($urandom);
    mplier   = W'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat      = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (noise && cyc >= 5 && cyc <= 8) begin
        start  = 1'b1;
        mcand  = W'($urandom);
        mplier = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (busy && done) check_eq({tag, " busy_and_done"}, 64'd1, 64'd0);
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    check_eq({tag, " latency"}, 64'(lat), 64'(W));
    check_eq({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W));
    check_eq({tag, " product"}, 64'(product), exp);
    @(posedge clk);
    #1;
    check_eq({tag, " done_one_cycle"}, 64'(done), 64'd0);
    check_eq({tag, " product_held"}, 64'(product), exp);
  endtask

  initial begin
    logic [W-1:0] a1, b1, a2, b2;
    logic [63:0]  p1;
    int           gap;
    bit           seen;
    n_checks = 0;
    n_errors = 0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);
    check_eq("reset product", 64'(product), 64'd0);

    run_op("1.5x1.5", 24'hC00000, 24'hC00000, 1'b0);
    run_op("max_x_max", 24'hFFFFFF, 24'hFFFFFF, 1'b0);
    run_op("half_x_half", 24'h800000, 24'h800000, 1'b0);
    run_op("zero_x_abcdef", 24'h000000, 24'hABCDEF, 1'b0);
    run_op("start_in_run", 24'hA5A5A5, 24'h5A5A5A, 1'b1);

    // Reset asserted after ten steps of a running operation.
    @(negedge clk);
    start  = 1'b1;
    mcand  = 24'hFFFFFF;
    mplier = 24'hFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrun_rst busy", 64'(busy), 64'd0);
    check_eq("midrun_rst done", 64'(done), 64'd0);
    check_eq("midrun_rst product", 64'(product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 24'h800001, 24'h800000, 1'b0);

    // Back-to-back with in_start held high, second operands shown in the DONE cycle.
    a1 = W'($urandom);
    b1 = W'($urandom);
    a2 = W'($urandom);
    b2 = W'($urandom);
    @(negedge clk);
    start  = 1'b1;
    mcand  = a1;
    mplier = b1;
    @(posedge clk);
    #1;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check_eq("b2b first_done_seen", 64'(seen), 64'd1);
    p1     = 64'(product);
    mcand  = a2;
    mplier = b2;
    check_eq("b2b first product", p1, ref_mul(a1, b1));
    gap  = 0;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        check_eq("b2b no_double_done", 64'(done), 64'd0);
        mcand  = W'($urandom);
        mplier = W'($urandom);
      end
      if (done) begin
        seen = 1'b1;
        gap  = cyc;
      end
    end
    start = 1'b0;
    check_eq("b2b gap", 64'(gap), 64'(W + 1));
    check_eq("b2b second product", 64'(product), ref_mul(a2, b2));
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mantissa_mul_seq.md
# mantissa_mul_seq

Sequential shift-and-add unsigned multiplier for the FP_Mul datapath. It is the multiplicative counterpart of the FP_Div one-bit restoring step chain. It takes two 24-bit significands (hidden bit included) and produces the full 48-bit product one multiplier bit per clock. FP_Mul normalisation and rounding consume the result.

## Interface
- WIDTH, 24, operand width in bits; product is 2*WIDTH bits.
- in_clk  input  1  rising-edge clock.
- in_rst  input  1  asynchronous, active-high reset.
- in_start  input  1  request; sampled on a rising edge while in IDLE or DONE.
- in_multiplicand  input  WIDTH  unsigned significand A; sampled with in_start.
- in_multiplier  input  WIDTH  unsigned significand B; sampled with in_start.
- out_busy  output  1  high while in RUN.
- out_done  output  1  one-cycle pulse; out_product valid.
- out_product  output  2*WIDTH  A*B; held until the next completion.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: out_busy=0, out_done=0, out_product=0, step counter=0, accumulator=0.
- IDLE: if in_start=1, latch A into the multiplicand register. Load the accumulator as {hi=0, lo=B}, clear the counter, and go to RUN.
- RUN: each cycle performs one step.
  - If lo[0]=1, compute {c,hi'} = hi + A using a WIDTH+1-bit sum. Otherwise c=0 and hi'=hi.
  - Shift {c,hi',lo} right by one, so the accumulator becomes {c,hi',lo}[2*WIDTH:1].
  - Increment the counter.
  - After step WIDTH-1 (counter==WIDTH-1), write the final accumulator to out_product and go to DONE.
- DONE: out_done=1 for this one cycle.
  - If in_start=1, accept the new operands exactly as in IDLE and go to RUN. This allows back-to-back operation.
  - Otherwise go to IDLE.
- in_start in RUN is ignored. The operands are not re-sampled and no error is flagged.
- The arithmetic is exact and unsigned, with no rounding or truncation. The carry c is never lost: the 48-bit result always equals A*B.
- in_rst asserted at any time, including mid-RUN, forces IDLE and all reset values immediately. The partial result is discarded. out_product returns to 0.
- Operands are needed only in the start cycle. Upstream may change them afterwards.

## Timing
- The start-sampling edge is edge 0. Steps execute on edges 1..WIDTH.
- out_busy=1 from after edge 0 until edge WIDTH.
- out_done=1 between edge WIDTH and edge WIDTH+1. Latency is WIDTH cycles, which is 24 by default.
- Sustained throughput with in_start held high is one product per WIDTH+1 cycles.
- out_product changes only on the completion edge or on reset. It is stable whenever out_done=1 and afterwards.
- out_busy and out_done are never high simultaneously. All outputs are registered.

## Structure
- The shared FP package holds:
  - the significand width constant (24) used as the WIDTH default;
  - the state encoding typedef (IDLE/RUN/DONE);
  - the product width constant (48).
- Sub-module onebit_mul_step is combinational.
  - Inputs: hi, lo, A.
  - Outputs: the shifted {hi,lo}.
  - It mirrors the one-bit division step so the FP_Div and FP_Mul datapaths stay symmetric.
- The top level holds the FSM, the counter (width ceil(log2(WIDTH))), the multiplicand register, the accumulator and the output register.

## Test plan
- Reset check: assert in_rst, then release it. Required: out_busy=0, out_done=0, out_product=0.
- Start A=0xC00000, B=0xC00000 (1.5×1.5). Required:
  - out_done pulses exactly 24 cycles after the start edge;
  - out_product=0x900000000000;
  - out_busy is high for exactly 24 cycles.
- Extreme operands:
  - A=B=0xFFFFFF gives 0xFFFFFE000001 (exercises the carry c);
  - A=B=0x800000 gives 0x400000000000;
  - A=0x000000, B=0xABCDEF gives 0.
- Start pulses during RUN, with changed operand values at step 5. Required: they are ignored and the result equals the originally latched A*B.
- Assert in_rst at step 10 of A=0xFFFFFF, B=0xFFFFFF. Required:
  - outputs are at reset values immediately;
  - a following start with A=0x800001, B=0x800000 yields 0x400000800000 with no residue.
- Back-to-back: hold in_start high with new operands presented in the DONE cycle. Required:
  - the second product completes 25 cycles after the first out_done;
  - both results are correct;
  - out_done is never high on two consecutive cycles.
